// File: rtl/count_event_unit.sv
// count_event_unit: Wishbone-mapped threshold compare, trigger-driven count
// capture FIFO and user interrupt generation for the user-area counter.
module count_event_unit #(
  parameter int unsigned BITS      = 16,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count_i,
  input  logic            trig_i,
  output logic [2:0]      irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CMP0   = 3'd1;
  localparam logic [2:0] OFF_CMP1   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_FIFO   = 3'd4;
  localparam logic [2:0] OFF_COUNT  = 3'd5;

  logic            ack_r;
  logic [31:0]     dat_r;
  logic [2:0]      irq_r;
  logic [2:0]      ctrl_r;
  logic [BITS-1:0] cmp0_r;
  logic [BITS-1:0] cmp1_r;
  logic            hit0_r;
  logic            hit1_r;
  logic            ovf_r;
  logic            m0_q_r;
  logic            m1_q_r;
  logic            sync1_r;
  logic            sync2_r;
  logic            trig_q_r;
  logic [BITS-1:0] mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;

  logic            req_s;
  logic            acc_s;
  logic            wr_s;
  logic            rd_s;
  logic [2:0]      off_s;
  logic [31:0]     wmask_s;
  logic [31:0]     rdata_s;
  logic [31:0]     level_ext_s;
  logic            m0_s;
  logic            m1_s;
  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            push_ok_s;
  logic            clr0_s;
  logic            clr1_s;
  logic            clr2_s;
  logic            unused_s;

  assign req_s   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  // Side effects happen only in the cycle that launches an acknowledge.
  assign acc_s   = req_s & ~ack_r;
  assign wr_s    = acc_s & wbs_we_i;
  assign rd_s    = acc_s & ~wbs_we_i;
  assign off_s   = wbs_adr_i[4:2];
  assign wmask_s = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign m0_s = ctrl_r[0] & (count_i == cmp0_r);
  assign m1_s = ctrl_r[1] & (count_i == cmp1_r);

  assign empty_s   = (level_r == {LW{1'b0}});
  assign full_s    = (level_r == LW'(DEPTH));
  assign pop_s     = rd_s & (off_s == OFF_FIFO) & ~empty_s;
  assign push_s    = sync2_r & ~trig_q_r & ctrl_r[2];
  // A push into a full FIFO still lands when a pop frees a slot the same cycle.
  assign push_ok_s = push_s & (~full_s | pop_s);

  assign clr0_s = wr_s & (off_s == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[0];
  assign clr1_s = wr_s & (off_s == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[1];
  assign clr2_s = wr_s & (off_s == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[2];

  assign level_ext_s = 32'(level_r);
  assign unused_s    = ^{wbs_adr_i[1:0], wbs_dat_i, wmask_s, level_ext_s};

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign irq       = irq_r;

  // Read-data multiplexer for the addressed register.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (off_s)
      OFF_CTRL:   rdata_s[2:0] = ctrl_r;
      OFF_CMP0:   rdata_s[BITS-1:0] = cmp0_r;
      OFF_CMP1:   rdata_s[BITS-1:0] = cmp1_r;
      OFF_STATUS: begin
        rdata_s[0]    = hit0_r;
        rdata_s[1]    = hit1_r;
        rdata_s[2]    = ovf_r;
        rdata_s[3]    = empty_s;
        rdata_s[4]    = full_s;
        rdata_s[11:8] = level_ext_s[3:0];
      end
      OFF_FIFO: begin
        if (!empty_s) begin
          rdata_s[BITS-1:0] = mem_r[rd_ptr_r];
        end else begin
          rdata_s = 32'h0000_0000;
        end
      end
      OFF_COUNT:  rdata_s[BITS-1:0] = count_i;
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  // Bus handshake: one-cycle ack and registered read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= acc_s;
      dat_r <= rd_s ? rdata_s : 32'h0000_0000;
    end
  end

  // Control and threshold registers with byte-lane write enables.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_r <= 3'b000;
      cmp0_r <= {BITS{1'b0}};
      cmp1_r <= {BITS{1'b0}};
    end else if (wr_s) begin
      case (off_s)
        OFF_CTRL: ctrl_r <= (ctrl_r & ~wmask_s[2:0]) | (wbs_dat_i[2:0] & wmask_s[2:0]);
        OFF_CMP0: cmp0_r <= (cmp0_r & ~wmask_s[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask_s[BITS-1:0]);
        OFF_CMP1: cmp1_r <= (cmp1_r & ~wmask_s[BITS-1:0]) | (wbs_dat_i[BITS-1:0] & wmask_s[BITS-1:0]);
        default:  ctrl_r <= ctrl_r;
      endcase
    end
  end

  // Sticky status flags; a new set event beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      hit0_r <= 1'b0;
      hit1_r <= 1'b0;
      ovf_r  <= 1'b0;
      m0_q_r <= 1'b0;
      m1_q_r <= 1'b0;
    end else begin
      hit0_r <= (m0_s & ~m0_q_r) | (hit0_r & ~clr0_s);
      hit1_r <= (m1_s & ~m1_q_r) | (hit1_r & ~clr1_s);
      ovf_r  <= (push_s & full_s & ~pop_s) | (ovf_r & ~clr2_s);
      m0_q_r <= m0_s;
      m1_q_r <= m1_s;
    end
  end

  // Two-flop synchroniser plus delayed copy for rising-edge detection.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      trig_q_r <= 1'b0;
    end else begin
      sync1_r  <= trig_i;
      sync2_r  <= sync1_r;
      trig_q_r <= sync2_r;
    end
  end

  // Capture FIFO pointers, occupancy and storage.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {BITS{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= count_i;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered interrupt lines.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_r <= 3'b000;
    end else begin
      irq_r <= {ovf_r | ~empty_s, hit1_r, hit0_r};
    end
  end

endmodule
